// File: rtl/fetch_unit_pkg.sv
// Shared fetch definitions: datapath widths, Thumb PC step and the
// fetch state encoding, visible to decode and hazard logic as well.
package fetch_unit_pkg;

    localparam int WORD      = 32;
    localparam int HALF_WORD = 16;

    localparam logic [WORD-1:0] THUMB_PC_INC = 32'd2;

    typedef enum logic [1:0] {
        BUBBLE = 2'd0,
        RUN    = 2'd1,
        HELD   = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Used by the fetch stage performance counters (FETCH_PERF_CNT_EN).
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // count up until all ones, then stick
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Thumb fetch stage: PC generation, one-entry stall hold buffer and
// branch squash. FETCH_PERF_CNT_EN adds saturating performance counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 stall_i,
    input  logic                 branch_taken_i,
    input  logic [WORD-1:0]      branch_target_i,
    input  logic [HALF_WORD-1:0] instruction_i,
    output logic [WORD-1:0]      program_counter_o,
    output logic                 instr_valid_o,
    output logic [HALF_WORD-1:0] instruction_o,
    output logic [WORD-1:0]      instr_pc_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          fetch_count_o,
    output logic [31:0]          stall_count_o,
    output logic [31:0]          redirect_count_o
`endif
);

    fetch_state_e         r_state;
    fetch_state_e         w_state_d;
    logic [WORD-1:0]      r_pc;
    logic [WORD-1:0]      w_pc_d;
    logic [WORD-1:0]      w_pc_inc;
    logic [WORD-1:0]      r_ifpc;
    logic [WORD-1:0]      w_ifpc_d;
    logic                 r_ifv;
    logic                 w_ifv_d;
    logic [HALF_WORD-1:0] r_hold_instr;
    logic [HALF_WORD-1:0] w_hold_instr_d;
    logic [WORD-1:0]      r_hold_pc;
    logic [WORD-1:0]      w_hold_pc_d;
    logic                 w_held;

    assign w_pc_inc = r_pc + THUMB_PC_INC;
    assign w_held   = (r_state == HELD);

    // next-state: redirect beats stall; a stall in RUN parks the
    // returning word so the memory can re-read the frozen PC
    always_comb begin
        w_state_d      = r_state;
        w_pc_d         = r_pc;
        w_ifpc_d       = r_ifpc;
        w_ifv_d        = r_ifv;
        w_hold_instr_d = r_hold_instr;
        w_hold_pc_d    = r_hold_pc;
        if (branch_taken_i) begin
            w_pc_d    = {branch_target_i[WORD-1:1], 1'b0};
            w_ifv_d   = 1'b0;
            w_state_d = BUBBLE;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (stall_i) begin
                        w_hold_instr_d = instruction_i;
                        w_hold_pc_d    = r_ifpc;
                        w_ifpc_d       = r_pc;
                        w_state_d      = HELD;
                    end else begin
                        w_pc_d    = w_pc_inc;
                        w_ifpc_d  = r_pc;
                        w_ifv_d   = 1'b1;
                        w_state_d = RUN;
                    end
                end
                HELD: begin
                    if (!stall_i) begin
                        w_pc_d    = w_pc_inc;
                        w_ifpc_d  = r_pc;
                        w_ifv_d   = 1'b1;
                        w_state_d = RUN;
                    end
                end
                default: begin
                    w_pc_d    = w_pc_inc;
                    w_ifpc_d  = r_pc;
                    w_ifv_d   = 1'b1;
                    w_state_d = RUN;
                end
            endcase
        end
    end

    // state and datapath registers, synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= BUBBLE;
            r_pc         <= RESET_VECTOR;
            r_ifpc       <= '0;
            r_ifv        <= 1'b0;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
        end else begin
            r_state      <= w_state_d;
            r_pc         <= w_pc_d;
            r_ifpc       <= w_ifpc_d;
            r_ifv        <= w_ifv_d;
            r_hold_instr <= w_hold_instr_d;
            r_hold_pc    <= w_hold_pc_d;
        end
    end

    // invalid cycles drive zeros so reset shows clean outputs
    assign program_counter_o = r_pc;
    assign instr_valid_o     = w_held | r_ifv;
    assign instruction_o     = w_held ? r_hold_instr :
                               (r_ifv ? instruction_i : '0);
    assign instr_pc_o        = w_held ? r_hold_pc :
                               (r_ifv ? r_ifpc : '0);

`ifdef FETCH_PERF_CNT_EN
    logic w_fetch_inc;
    logic w_stall_inc;

    assign w_fetch_inc = instr_valid_o & ~stall_i;
    assign w_stall_inc = instr_valid_o & stall_i;

    sat_counter #(.WIDTH(32)) u_fetch_cnt (
        .i_clk   (clk_i),
        .i_clr   (reset_i),
        .i_inc   (w_fetch_inc),
        .o_count (fetch_count_o)
    );

    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .i_clk   (clk_i),
        .i_clr   (reset_i),
        .i_inc   (w_stall_inc),
        .o_count (stall_count_o)
    );

    sat_counter #(.WIDTH(32)) u_redir_cnt (
        .i_clk   (clk_i),
        .i_clr   (reset_i),
        .i_inc   (branch_taken_i),
        .o_count (redirect_count_o)
    );
`endif

endmodule
